// File: rtl/rf_cmd_pkg.sv
// rf_cmd_pkg: opcodes and FSM states shared by the register-file command parser.
package rf_cmd_pkg;
  localparam logic [7:0] CMD_RF_WR = 8'hAA;
  localparam logic [7:0] CMD_RF_RD = 8'hBB;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX} state_t;
endpackage

// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: parses UART RX bytes into register-file write/read frames and forwards read data to the TX FIFO.
module rf_cmd_ctrl
  import rf_cmd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [WIDTH-1:0]  WrData,
  input  logic [WIDTH-1:0]  RdData,
  input  logic              RdValid,
  output logic [WIDTH-1:0]  TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              FIFO_FULL,
  output logic              CMD_ERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WIDTH-1:0] wr_data_n, tx_data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wr_en_n, rd_en_n, tx_vld_n, err_n, addr_bad;
  assign addr_bad = (RX_P_DATA >> ADDR_W) != '0;
  always_comb begin
    state_n   = state;
    addr_n    = Address;
    wr_data_n = WrData;
    tx_data_n = TX_P_DATA;
    cnt_n     = cnt;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == WIDTH'(CMD_RF_WR)) state_n = WR_ADDR;
        else if (RX_P_DATA == WIDTH'(CMD_RF_RD)) state_n = RD_ADDR;
        else err_n = 1'b1;
      end
      WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
        if (addr_bad) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          addr_n  = RX_P_DATA[ADDR_W-1:0];
          rd_en_n = (state == RD_ADDR);
          state_n = (state == RD_ADDR) ? RD_REQ : WR_DATA;
        end
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_en_n   = 1'b1;
        wr_data_n = RX_P_DATA;
        state_n   = IDLE;
      end
      RD_REQ: begin
        err_n   = RX_D_VLD;
        cnt_n   = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        err_n = RX_D_VLD;
        if (RdValid) begin
          tx_data_n = RdData;
          cnt_n     = '0;
          state_n   = TX;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else cnt_n = cnt + CW'(1);
      end
      TX: begin
        err_n    = RX_D_VLD;
        tx_vld_n = !FIFO_FULL;
        state_n  = FIFO_FULL ? TX : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      Address   <= addr_n;
      WrEn      <= wr_en_n;
      RdEn      <= rd_en_n;
      WrData    <= wr_data_n;
      TX_P_DATA <= tx_data_n;
      TX_D_VLD  <= tx_vld_n;
      CMD_ERR   <= err_n;
    end
  end
endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// tb_rf_cmd_ctrl: directed and randomized frames against a frame-level model of the command parser.
module tb_rf_cmd_ctrl;
  localparam int TIMEOUT = 8;
  logic CLK = 1'b0;
  logic rst_n, rx_vld, rd_valid, full;
  logic [7:0] rx_data, rd_data;
  logic [3:0] Address;
  logic WrEn, RdEn, TX_D_VLD, CMD_ERR;
  logic [7:0] WrData, TX_P_DATA;
  int errors = 0, checks = 0;
  bit go = 0;
  always #5 CLK = ~CLK;

  rf_cmd_ctrl #(.DEPTH(16), .WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(rst_n), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(rd_data), .RdValid(rd_valid), .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD(TX_D_VLD), .FIFO_FULL(full), .CMD_ERR(CMD_ERR)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes collect into a frame; a read in flight is tracked by age and a held result.
  logic [7:0] frame[$];
  bit rd_busy, have;
  int age;
  logic [3:0] e_addr;
  logic [7:0] e_wd, e_txd;
  bit e_wr, e_rd, e_tv, e_err;
  always @(posedge CLK or negedge rst_n) begin
    e_wr = 0; e_rd = 0; e_tv = 0; e_err = 0;
    if (!rst_n) begin
      frame.delete(); rd_busy = 0; have = 0; age = 0;
      e_addr = 0; e_wd = 0; e_txd = 0;
    end else if (rd_busy) begin
      if (rx_vld) e_err = 1;
      if (age == 0) age = 1;
      else if (have) begin
        if (!full) begin e_tv = 1; rd_busy = 0; end
      end else if (rd_valid) begin have = 1; e_txd = rd_data; end
      else if (age == TIMEOUT) begin e_err = 1; rd_busy = 0; end
      else age++;
    end else if (rx_vld) begin
      frame.push_back(rx_data);
      if (frame.size() == 1 && rx_data != 8'hAA && rx_data != 8'hBB) begin
        e_err = 1; frame.delete();
      end else if (frame.size() == 2) begin
        if (rx_data > 8'd15) begin e_err = 1; frame.delete(); end
        else begin
          e_addr = rx_data[3:0];
          if (frame[0] == 8'hBB) begin
            e_rd = 1; rd_busy = 1; have = 0; age = 0; frame.delete();
          end
        end
      end else if (frame.size() == 3) begin
        e_wr = 1; e_wd = rx_data; frame.delete();
      end
    end
    #1;
    if (go) begin
      chk("Address", Address, e_addr);
      chk("WrEn", WrEn, e_wr);
      chk("WrData", WrData, e_wd);
      chk("RdEn", RdEn, e_rd);
      chk("TX_P_DATA", TX_P_DATA, e_txd);
      chk("TX_D_VLD", TX_D_VLD, e_tv);
      chk("CMD_ERR", CMD_ERR, e_err);
      chk("WrEn_RdEn_excl", WrEn & RdEn, 0);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK); rx_vld = 1; rx_data = b;
    @(negedge CLK); rx_vld = 0;
  endtask

  initial begin
    int got;
    rst_n = 0; rx_vld = 0; rx_data = 0; rd_valid = 0; rd_data = 0; full = 0;
    repeat (2) @(posedge CLK);
    go = 1;
    @(negedge CLK);
    chk("rst_outputs", {Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    rst_n = 1;
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_en", WrEn, 1); chk("wr_addr", Address, 5); chk("wr_data", WrData, 8'h3C);
    @(negedge CLK); chk("wr_single", WrEn, 0);
    send(8'hBB); send(8'h02);
    chk("rd_en", RdEn, 1); chk("rd_addr", Address, 2);
    @(negedge CLK); chk("rd_single", RdEn, 0);
    rd_valid = 1; rd_data = 8'h81;
    @(negedge CLK); rd_valid = 0;
    chk("rd_capture", TX_P_DATA, 8'h81); chk("tx_not_yet", TX_D_VLD, 0);
    @(negedge CLK); chk("tx_vld", TX_D_VLD, 1); chk("tx_data", TX_P_DATA, 8'h81);
    @(negedge CLK); chk("tx_single", TX_D_VLD, 0);
    full = 1;
    send(8'hBB); send(8'h04);
    @(negedge CLK); rd_valid = 1; rd_data = 8'h5A;
    @(negedge CLK); rd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); chk("full_hold_vld", TX_D_VLD, 0); chk("full_hold_data", TX_P_DATA, 8'h5A);
    end
    full = 0;
    @(negedge CLK); chk("full_release", TX_D_VLD, 1);
    @(negedge CLK); chk("full_once", TX_D_VLD, 0);
    send(8'h12); chk("bad_opcode", CMD_ERR, 1);
    send(8'hAA); chk("no_err_opcode", CMD_ERR, 0);
    send(8'h20); chk("bad_addr", CMD_ERR, 1);
    send(8'hAA); send(8'h01); send(8'hFF);
    chk("wr2_en", WrEn, 1); chk("wr2_addr", Address, 1); chk("wr2_data", WrData, 8'hFF);
    send(8'hBB); send(8'h03);
    got = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (CMD_ERR) begin got = i; break; end
    end
    chk("timeout_cycles", got, TIMEOUT + 1);
    send(8'hAA); send(8'h07);
    @(negedge CLK); rst_n = 0;
    #1 chk("mid_rst_outputs", {Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    @(negedge CLK); rst_n = 1;
    send(8'h55); chk("post_rst_err", CMD_ERR, 1); chk("post_rst_no_wr", WrEn, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      rst_n = ($urandom_range(0, 299) != 0);
      rx_vld = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 9))
        0, 1: rx_data = 8'hAA;
        2, 3: rx_data = 8'hBB;
        4, 5, 6: rx_data = 8'($urandom_range(0, 15));
        default: rx_data = 8'($urandom);
      endcase
      rd_valid = ($urandom_range(0, 9) < 3);
      rd_data = 8'($urandom);
      full = ($urandom_range(0, 9) < 4);
    end
    @(negedge CLK); rst_n = 1; rx_vld = 0; rd_valid = 0; full = 0;
    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
